// File: rtl/m6809_core_rti.sv
// m6809_core_rti: RTI pull sequencer.
// Pulls CC from the S stack and, when the pulled CC has E set, the rest of
// the entire frame (A, B, DP, X, Y, U, PC); otherwise only PC. One byte is
// pulled per cycle. Each pulled register is presented on its output with a
// one-cycle write strobe. S+1 is presented on s_out with s_out_en in every
// pull cycle.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start, ir_in        request, accepted only when ir_in == 8'h3B
//   din, s_in           memory read data (same cycle as addr), current S
//   addr, data_rw_n     bus address (0 when idle), always-read flag
//   bus_oe              high while a pull cycle owns the bus
//   *_out / *_out_en    register write-back data and strobes (data 0 when strobe low)
//   busy, done          sequence active, final pull cycle
//
// state | meaning
// ------+------------------------------------------------
// IDLE  | waiting for start with an RTI opcode
// P_CC  | pull CC, decide frame length from its E bit
// P_A   | pull A
// P_B   | pull B
// P_DP  | pull DP
// P_XH  | pull X high byte into temp
// P_XL  | pull X low byte, write X
// P_YH  | pull Y high byte into temp
// P_YL  | pull Y low byte, write Y
// P_UH  | pull U high byte into temp
// P_UL  | pull U low byte, write U
// P_PCH | pull PC high byte into temp
// P_PCL | pull PC low byte, write PC, done
module m6809_core_rti (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  ir_in,
    input  logic [7:0]  din,
    input  logic [15:0] s_in,
    output logic [15:0] addr,
    output logic        data_rw_n,
    output logic        bus_oe,
    output logic [7:0]  ccr_out,
    output logic [7:0]  a_out,
    output logic [7:0]  b_out,
    output logic [7:0]  dpr_out,
    output logic [15:0] x_out,
    output logic [15:0] y_out,
    output logic [15:0] u_out,
    output logic [15:0] pc_out,
    output logic [15:0] s_out,
    output logic        ccr_out_en,
    output logic        a_out_en,
    output logic        b_out_en,
    output logic        dpr_out_en,
    output logic        x_out_en,
    output logic        y_out_en,
    output logic        u_out_en,
    output logic        pc_out_en,
    output logic        s_out_en,
    output logic        busy,
    output logic        done
);

    typedef enum logic [3:0] {
        IDLE, P_CC, P_A, P_B, P_DP, P_XH, P_XL,
        P_YH, P_YL, P_UH, P_UL, P_PCH, P_PCL
    } state_t;

    localparam logic [7:0] OP_RTI = 8'h3B;

    state_t     state_q, state_d;
    logic [7:0] temp_q, temp_d;
    logic       e_q, e_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            temp_q  <= 8'h00;
            e_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            temp_q  <= temp_d;
            e_q     <= e_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        temp_d     = temp_q;
        e_d        = e_q;
        addr       = 16'h0000;
        data_rw_n  = 1'b1;
        bus_oe     = 1'b0;
        ccr_out    = 8'h00;
        a_out      = 8'h00;
        b_out      = 8'h00;
        dpr_out    = 8'h00;
        x_out      = 16'h0000;
        y_out      = 16'h0000;
        u_out      = 16'h0000;
        pc_out     = 16'h0000;
        s_out      = 16'h0000;
        ccr_out_en = 1'b0;
        a_out_en   = 1'b0;
        b_out_en   = 1'b0;
        dpr_out_en = 1'b0;
        x_out_en   = 1'b0;
        y_out_en   = 1'b0;
        u_out_en   = 1'b0;
        pc_out_en  = 1'b0;
        s_out_en   = 1'b0;
        busy       = (state_q != IDLE);
        done       = 1'b0;

        // Every pull cycle reads at S and post-increments S (wraps at 16 bits).
        if (state_q != IDLE) begin
            addr     = s_in;
            bus_oe   = 1'b1;
            s_out    = s_in + 16'd1;
            s_out_en = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start && (ir_in == OP_RTI))
                    state_d = P_CC;
            end
            P_CC: begin
                ccr_out    = din;
                ccr_out_en = 1'b1;
                // Frame length comes only from the byte just pulled.
                e_d        = din[7];
                state_d    = din[7] ? P_A : P_PCH;
            end
            P_A: begin
                a_out    = din;
                a_out_en = 1'b1;
                state_d  = P_B;
            end
            P_B: begin
                b_out    = din;
                b_out_en = 1'b1;
                state_d  = P_DP;
            end
            P_DP: begin
                dpr_out    = din;
                dpr_out_en = 1'b1;
                state_d    = P_XH;
            end
            P_XH: begin
                temp_d  = din;
                state_d = P_XL;
            end
            P_XL: begin
                x_out    = {temp_q, din};
                x_out_en = 1'b1;
                state_d  = P_YH;
            end
            P_YH: begin
                temp_d  = din;
                state_d = P_YL;
            end
            P_YL: begin
                y_out    = {temp_q, din};
                y_out_en = 1'b1;
                state_d  = P_UH;
            end
            P_UH: begin
                temp_d  = din;
                state_d = P_UL;
            end
            P_UL: begin
                u_out    = {temp_q, din};
                u_out_en = 1'b1;
                state_d  = P_PCH;
            end
            P_PCH: begin
                temp_d  = din;
                state_d = P_PCL;
            end
            P_PCL: begin
                pc_out    = {temp_q, din};
                pc_out_en = 1'b1;
                done      = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_m6809_core_rti.sv
// tb_m6809_core_rti: directed bench for the RTI pull sequencer.
// A byte-wide memory model answers addr combinationally; a local S register
// plays the integration layer, taking s_out on s_out_en.
module tb_m6809_core_rti;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  ir_in;
    logic [7:0]  din;
    logic [15:0] s_in;
    logic [15:0] addr;
    logic        data_rw_n;
    logic        bus_oe;
    logic [7:0]  ccr_out, a_out, b_out, dpr_out;
    logic [15:0] x_out, y_out, u_out, pc_out, s_out;
    logic        ccr_out_en, a_out_en, b_out_en, dpr_out_en;
    logic        x_out_en, y_out_en, u_out_en, pc_out_en, s_out_en;
    logic        busy, done;

    logic [7:0]  mem [0:65535];
    logic [15:0] s_reg;
    logic        s_load;
    logic [15:0] s_load_val;

    int total = 0;
    int bad   = 0;

    m6809_core_rti dut (
        .clk(clk), .reset(reset), .start(start), .ir_in(ir_in), .din(din), .s_in(s_in),
        .addr(addr), .data_rw_n(data_rw_n), .bus_oe(bus_oe),
        .ccr_out(ccr_out), .a_out(a_out), .b_out(b_out), .dpr_out(dpr_out),
        .x_out(x_out), .y_out(y_out), .u_out(u_out), .pc_out(pc_out), .s_out(s_out),
        .ccr_out_en(ccr_out_en), .a_out_en(a_out_en), .b_out_en(b_out_en),
        .dpr_out_en(dpr_out_en), .x_out_en(x_out_en), .y_out_en(y_out_en),
        .u_out_en(u_out_en), .pc_out_en(pc_out_en), .s_out_en(s_out_en),
        .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign din  = mem[addr];
    assign s_in = s_reg;

    always @(posedge clk) begin
        if (s_load)
            s_reg <= s_load_val;
        else if (s_out_en)
            s_reg <= s_out;
    end

    function automatic logic [7:0] en_mask();
        return {pc_out_en, u_out_en, y_out_en, x_out_en,
                dpr_out_en, b_out_en, a_out_en, ccr_out_en};
    endfunction

    function automatic logic [15:0] en_val();
        logic [15:0] v;
        v = 16'h0000;
        case (en_mask())
            8'h01: v = {8'h00, ccr_out};
            8'h02: v = {8'h00, a_out};
            8'h04: v = {8'h00, b_out};
            8'h08: v = {8'h00, dpr_out};
            8'h10: v = x_out;
            8'h20: v = y_out;
            8'h40: v = u_out;
            8'h80: v = pc_out;
            default: v = 16'h0000;
        endcase
        return v;
    endfunction

    // Per-cycle invariants: strobes one-hot-or-zero, never a write, quiet when idle.
    always @(posedge clk) begin
        #2;
        total++;
        if (!$onehot0(en_mask()) || data_rw_n !== 1'b1) begin
            bad++;
            $display("FAIL invariant t=%0t mask=%h rw_n=%b req onehot0 rw_n=1", $time, en_mask(), data_rw_n);
        end
        if (busy === 1'b0) begin
            total++;
            if ((addr | s_out | x_out | y_out | u_out | pc_out) !== 16'h0000 ||
                (ccr_out | a_out | b_out | dpr_out | en_mask()) !== 8'h00 ||
                {bus_oe, done, s_out_en} !== 3'b000) begin
                bad++;
                $display("FAIL idle_quiet t=%0t addr=%h mask=%h bus_oe=%b done=%b req all zero",
                         $time, addr, en_mask(), bus_oe, done);
            end
        end
    end

    task automatic load_s(input logic [15:0] v);
        @(negedge clk);
        s_load = 1'b1;
        s_load_val = v;
        @(negedge clk);
        s_load = 1'b0;
    endtask

    task automatic kick();
        @(negedge clk);
        start = 1'b1;
        ir_in = 8'h3B;
        @(negedge clk);
        start = 1'b0;
        ir_in = 8'h00;
        #1;
    endtask

    task automatic put_long(input logic [15:0] base);
        logic [7:0] b [12] = '{8'h80, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55,
                               8'h66, 8'h77, 8'h88, 8'h99, 8'hAB, 8'hCD};
        for (int i = 0; i < 12; i++) mem[base + 16'(i)] = b[i];
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({busy, done, bus_oe, en_mask(), addr} !== 27'd0) begin
            bad++;
            $display("FAIL reset_state busy=%b done=%b bus_oe=%b mask=%h addr=%h req zeros",
                     busy, done, bus_oe, en_mask(), addr);
        end
        reset = 1'b0;
    endtask

    task automatic test_short(input string nm, input logic [15:0] base, input logic stray_start);
        logic [7:0]  em [3] = '{8'h01, 8'h00, 8'h80};
        logic [15:0] ev [3] = '{16'h0005, 16'h0000, 16'h1234};
        logic [15:0] ea;
        mem[base] = 8'h05;
        mem[base + 16'd1] = 8'h12;
        mem[base + 16'd2] = 8'h34;
        load_s(base);
        kick();
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                @(negedge clk);
                #1;
            end
            ea = base + 16'(k);
            total++;
            if ({addr, s_out} !== {ea, ea + 16'd1}) begin
                bad++;
                $display("FAIL %s_addr c%0d addr=%h s_out=%h req %h %h", nm, k, addr, s_out, ea, ea + 16'd1);
            end
            total++;
            if ({en_mask(), en_val()} !== {em[k], ev[k]}) begin
                bad++;
                $display("FAIL %s_data c%0d mask=%h val=%h req %h %h", nm, k, en_mask(), en_val(), em[k], ev[k]);
            end
            total++;
            if ({done, busy, bus_oe, s_out_en} !== {(k == 2), 3'b111}) begin
                bad++;
                $display("FAIL %s_ctl c%0d done/busy/oe/sen=%b%b%b%b req %b111", nm, k, done, busy, bus_oe, s_out_en, (k == 2));
            end
            if (stray_start && k == 2) begin
                start = 1'b1;
                ir_in = 8'h3B;
            end
        end
        @(negedge clk);
        start = 1'b0;
        ir_in = 8'h00;
        #1;
        total++;
        if ({busy, s_reg} !== {1'b0, base + 16'd3}) begin
            bad++;
            $display("FAIL %s_end busy=%b s=%h req 0 %h", nm, busy, s_reg, base + 16'd3);
        end
        @(negedge clk);
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_restart busy=%b req 0", nm, busy);
        end
    endtask

    task automatic test_entire(input string nm, input logic [15:0] base, input int stray_cycle);
        logic [7:0]  em [12] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h00, 8'h10,
                                 8'h00, 8'h20, 8'h00, 8'h40, 8'h00, 8'h80};
        logic [15:0] ev [12] = '{16'h0080, 16'h0011, 16'h0022, 16'h0033, 16'h0000, 16'h4455,
                                 16'h0000, 16'h6677, 16'h0000, 16'h8899, 16'h0000, 16'hABCD};
        put_long(base);
        load_s(base);
        kick();
        for (int k = 0; k < 12; k++) begin
            if (k > 0) begin
                @(negedge clk);
                start = 1'b0;
                ir_in = 8'h00;
                #1;
            end
            total++;
            if (addr !== base + 16'(k)) begin
                bad++;
                $display("FAIL %s_addr c%0d addr=%h req %h", nm, k, addr, base + 16'(k));
            end
            total++;
            if ({en_mask(), en_val()} !== {em[k], ev[k]}) begin
                bad++;
                $display("FAIL %s_data c%0d mask=%h val=%h req %h %h", nm, k, en_mask(), en_val(), em[k], ev[k]);
            end
            total++;
            if ({done, busy} !== {(k == 11), 1'b1}) begin
                bad++;
                $display("FAIL %s_ctl c%0d done=%b busy=%b req %b 1", nm, k, done, busy, (k == 11));
            end
            if (k == stray_cycle) begin
                start = 1'b1;
                ir_in = 8'h3B;
            end
        end
        @(negedge clk);
        #1;
        total++;
        if ({busy, s_reg} !== {1'b0, base + 16'd12}) begin
            bad++;
            $display("FAIL %s_end busy=%b s=%h req 0 %h", nm, busy, s_reg, base + 16'd12);
        end
    endtask

    task automatic test_bad_opcode();
        @(negedge clk);
        start = 1'b1;
        ir_in = 8'h35;
        @(negedge clk);
        start = 1'b0;
        ir_in = 8'h00;
        #1;
        total++;
        if ({busy, bus_oe} !== 2'b00) begin
            bad++;
            $display("FAIL bad_opcode busy=%b bus_oe=%b req 0 0", busy, bus_oe);
        end
    endtask

    task automatic test_reset_mid();
        put_long(16'h3000);
        load_s(16'h3000);
        kick();
        repeat (5) @(negedge clk);
        #1;
        total++;
        if ({addr, en_mask()} !== {16'h3005, 8'h10}) begin
            bad++;
            $display("FAIL mid_in_xl addr=%h mask=%h req 3005 10", addr, en_mask());
        end
        reset = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if ({busy, done, en_mask(), s_out_en} !== 11'd0) begin
            bad++;
            $display("FAIL mid_reset busy=%b done=%b mask=%h sen=%b req zeros", busy, done, en_mask(), s_out_en);
        end
        // reset and start on the same edge: reset wins
        start = 1'b1;
        ir_in = 8'h3B;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        ir_in = 8'h00;
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_prio busy=%b req 0", busy);
        end
        // start accepted on the first edge after reset release
        start = 1'b1;
        ir_in = 8'h3B;
        @(negedge clk);
        start = 1'b0;
        ir_in = 8'h00;
        #1;
        total++;
        if ({busy, en_mask()} !== {1'b1, 8'h01}) begin
            bad++;
            $display("FAIL post_reset_start busy=%b mask=%h req 1 01", busy, en_mask());
        end
        // S now points past the CC byte of the aborted frame; drain whatever runs
        repeat (12) @(negedge clk);
        test_short("after_reset", 16'h5000, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        ir_in = 8'h00;
        s_load = 1'b0;
        s_load_val = 16'h0000;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        test_reset();
        test_short("short", 16'h1000, 1'b0);
        test_entire("entire", 16'h2000, -1);
        test_short("after_long", 16'h1100, 1'b0);
        test_short("wrap", 16'hFFFE, 1'b0);
        test_bad_opcode();
        test_entire("start_in_pb", 16'h2100, 2);
        test_short("start_in_pcl", 16'h1200, 1'b1);
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/m6809_core_rti.md
M6809_CORE_RTI -- requirements
Module: m6809_core_rti

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port start  input  1  one-cycle request, qualified by ir_in == 8'h3B (RTI).
REQ-004 SHALL have port ir_in  input  8  instruction register.
REQ-005 SHALL have port din  input  8  memory read data, valid in the same cycle as addr.
REQ-006 SHALL have port s_in  input  16  current S; the integration layer writes s_out back on s_out_en.
REQ-007 SHALL have port addr  output  16  memory address; 0 when idle.
REQ-008 SHALL have port data_rw_n  output  1  constant 1; block never writes memory.
REQ-009 SHALL have port bus_oe  output  1  high while a pull cycle owns the bus.
REQ-010 SHALL have ports ccr_out, a_out, b_out, dpr_out  output  8 each  and x_out, y_out, u_out, pc_out, s_out  output  16 each; each data output 0 when its enable is low.
REQ-011 SHALL have ports ccr_out_en, a_out_en, b_out_en, dpr_out_en, x_out_en, y_out_en, u_out_en, pc_out_en, s_out_en  output  1 each  one-cycle write strobes.
REQ-012 SHALL have ports busy  output  1  (state != IDLE) and done  output  1  (high in the final pull cycle).

Function
REQ-013 SHALL implement states IDLE, P_CC, P_A, P_B, P_DP, P_XH, P_XL, P_YH, P_YL, P_UH, P_UL, P_PCH, P_PCL.
REQ-014 IDLE -> P_CC on the edge where start & (ir_in == 8'h3B); start with any other ir_in SHALL be ignored.
REQ-015 start while busy SHALL be ignored; the sequence in progress continues unchanged.
REQ-016 Every non-IDLE state is one pull cycle: addr = s_in, bus_oe = 1, s_out = s_in + 1 (mod 2^16, FFFF -> 0000), s_out_en = 1.
REQ-017 P_CC: ccr_out = din, ccr_out_en = 1; latch e_q = din[7]; next state P_A if din[7] = 1, else P_PCH.
REQ-018 Entire-frame order SHALL be P_A, P_B, P_DP, P_XH, P_XL, P_YH, P_YL, P_UH, P_UL, P_PCH, then P_PCL, advancing one state per cycle.
REQ-019 P_A / P_B / P_DP: drive din on a_out / b_out / dpr_out with the matching enable for that cycle.
REQ-020 High-byte states (P_XH, P_YH, P_UH, P_PCH) SHALL latch din into an 8-bit temp register and assert no register enable except s_out_en.
REQ-021 Low-byte states (P_XL, P_YL, P_UL, P_PCL) SHALL drive {temp, din} on the matching 16-bit output with its enable for that cycle.
REQ-022 P_PCL SHALL assert done and return to IDLE on the next edge; start in that cycle is ignored.
REQ-023 At most one of ccr/a/b/dpr/x/y/u/pc enables SHALL be high in any cycle; s_out_en is independent.
REQ-024 Latency: E = 0 frame 3 pull cycles (S + 3); E = 1 frame 12 pull cycles (S + 12); busy high for exactly that count.
REQ-025 E SHALL be taken only from the pulled CC byte, never from the CC value held before start.
REQ-026 In IDLE all enables, bus_oe, busy, done SHALL be 0, and addr and all data outputs 0.

Reset
REQ-027 reset high at a rising edge SHALL force IDLE and clear temp and e_q, including mid-sequence; no enable asserts in the cycle after reset.
REQ-028 reset SHALL take priority over start on the same edge.
REQ-029 After reset deasserts, the block SHALL accept start on the next edge.

Verification
REQ-030 Short frame: S = 0x1000, mem[1000..1002] = 0x05, 0x12, 0x34 -> ccr_out_en with 0x05, then pc_out = 0x1234 with done in cycle 3; final S = 0x1003; no a/b/dp/x/y/u enables.
REQ-031 Entire frame: S = 0x2000, mem = 80, 11, 22, 33, 44, 55, 66, 77, 88, 99, AB, CD -> CC = 0x80, A = 0x11, B = 0x22, DP = 0x33, X = 0x4455, Y = 0x6677, U = 0x8899, PC = 0xABCD, 12 cycles, final S = 0x200C.
REQ-032 Wrap-around: S = 0xFFFE, short frame -> addresses FFFE, FFFF, 0000; final S = 0x0001.
REQ-033 Ignored start: start with ir_in = 0x35, or start during P_B of a long frame -> no state change, sequence unaffected.
REQ-034 Reset mid-op: reset asserted in P_XL -> next cycle IDLE, no enables; a new RTI then completes normally.
REQ-035 Every cycle: enable one-hot-or-zero check, and data_rw_n == 1 at all times.
